// File: rtl/clk_synth_pkg.sv
// Shared types and helpers for the clock-enable synthesiser.
// Holds the lock FSM states, the default width and a rate-to-increment helper.
package clk_synth_pkg;

    localparam int DEFAULT_ACC_WIDTH = 24;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Rounded NCO increment giving f_out from f_ref with a width-bit accumulator.
    function automatic longint unsigned inc_for(input longint unsigned f_out,
                                                input longint unsigned f_ref,
                                                input int width);
        return ((f_out << width) + (f_ref >> 1)) / f_ref;
    endfunction

endpackage

// File: rtl/clk_synth_nco.sv
// One NCO channel: phase accumulator, increment register, enable pulse and square wave.
// Latency: ce_out one cycle after the overflowing add; no backpressure.
// clear realigns phase and drops ce_out while clk_out holds its level.
module clk_synth_nco #(
    parameter int                   ACC_WIDTH = 24,
    parameter logic [ACC_WIDTH-1:0] RESET_INC = ACC_WIDTH'(1 << (ACC_WIDTH-1))
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] load_inc,
    input  logic                 ce_en,
    output logic                 ce_out,
    output logic                 clk_out
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc     <= '0;
            inc     <= RESET_INC;
            ce_out  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            if (load) begin
                inc <= load_inc;
            end
            if (clear) begin
                acc    <= '0;
                ce_out <= 1'b0;
            end else begin
                acc     <= sum[ACC_WIDTH-1:0];
                ce_out  <= sum[ACC_WIDTH] & ce_en;
                clk_out <= clk_out ^ ce_out;
            end
        end
    end

endmodule

// File: rtl/clk_enable_synth.sv
// Multi-channel NCO clock-enable synthesiser with a PLL-style settle/lock indication.
// Latency: accepted cfg drops locked the same edge; locked returns LOCK_DELAY edges later.
// cfg_ready is high on every edge after reset release; out-of-range channels are dropped.
module clk_enable_synth
    import clk_synth_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int ACC_WIDTH    = DEFAULT_ACC_WIDTH,
    parameter int LOCK_DELAY   = 1024,
    parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] INC_RESET =
        {NUM_CHANNELS{ACC_WIDTH'(1 << (ACC_WIDTH-1))}},
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         cfg_channel,
    input  logic [ACC_WIDTH-1:0]    cfg_increment,
    output logic [NUM_CHANNELS-1:0] ce_out,
    output logic [NUM_CHANNELS-1:0] clk_out,
    output logic                    locked
);

    localparam int               CNT_W    = $clog2(LOCK_DELAY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DELAY - 1);
    localparam logic [CH_W:0]    NUM_CH   = (CH_W+1)'(NUM_CHANNELS);

    lock_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             locked_nxt;
    logic             accept;

    assign accept = cfg_valid & cfg_ready & ({1'b0, cfg_channel} < NUM_CH);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= SETTLE;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            locked    <= locked_nxt;
            cfg_ready <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        locked_nxt = locked;
        if (accept) begin
            state_nxt  = SETTLE;
            cnt_nxt    = '0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    locked_nxt = 1'b1;
                end
                default: begin
                    state_nxt = SETTLE;
                end
            endcase
        end
    end

    // Every channel restarts from zero phase on any accepted cfg so rates stay aligned.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_nco
        clk_synth_nco #(
            .ACC_WIDTH (ACC_WIDTH),
            .RESET_INC (INC_RESET[i*ACC_WIDTH +: ACC_WIDTH])
        ) u_nco (
            .refclk   (refclk),
            .rst      (rst),
            .clear    (accept),
            .load     (accept && (cfg_channel == CH_W'(i))),
            .load_inc (cfg_increment),
            .ce_en    (state == LOCKED),
            .ce_out   (ce_out[i]),
            .clk_out  (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_enable_synth.sv
// Self-checking bench: cycle-accurate reference model plus directed rate/lock checks.
module tb_clk_enable_synth;
    import clk_synth_pkg::*;

    localparam int NCH = 3;
    localparam int W   = 24;
    localparam int LD  = 16;
    localparam longint unsigned MOD = longint'(1) << W;

    logic           refclk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_channel = '0;
    logic [W-1:0]   cfg_increment = '0;
    logic [NCH-1:0] ce_out;
    logic [NCH-1:0] clk_out;
    logic           locked;

    clk_enable_synth #(.NUM_CHANNELS(NCH), .ACC_WIDTH(W), .LOCK_DELAY(LD)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_channel(cfg_channel), .cfg_increment(cfg_increment),
        .ce_out(ce_out), .clk_out(clk_out), .locked(locked)
    );

    always #5 refclk = ~refclk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: phase as integers, lock as "edges since last restart".
    longint unsigned m_acc[NCH];
    longint unsigned m_inc[NCH];
    bit              m_ce[NCH];
    bit              m_clk[NCH];
    int              m_since;
    bit              m_ready;

    int st_cnt[NCH], st_min[NCH], st_max[NCH], st_last[NCH];
    int st_clkmin, st_clkmax, st_clklast, st_misalign;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit acc_ok;
        longint unsigned s;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_inc[i] = longint'(1) << (W-1); m_ce[i] = 0; m_clk[i] = 0;
            end
            m_since = 0;
            m_ready = 0;
        end else begin
            acc_ok = cfg_valid && m_ready && (int'(cfg_channel) < NCH);
            m_ready = 1;
            if (acc_ok) begin
                m_inc[cfg_channel] = longint'(cfg_increment);
                for (int i = 0; i < NCH; i++) begin
                    m_acc[i] = 0; m_ce[i] = 0;
                end
                m_since = 0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    s = m_acc[i] + m_inc[i];
                    m_clk[i] = m_clk[i] ^ m_ce[i];
                    m_ce[i] = (s >= MOD) && (m_since >= LD);
                    m_acc[i] = s % MOD;
                end
                if (m_since < 1000000) m_since++;
            end
        end
    endtask

    task automatic step();
        logic [NCH-1:0] e_ce, e_clk;
        @(posedge refclk);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) begin
            e_ce[i] = m_ce[i]; e_clk[i] = m_clk[i];
        end
        chk("ce_out", ce_out, e_ce);
        chk("clk_out", clk_out, e_clk);
        chk("locked", locked, m_since >= LD);
        chk("cfg_ready", cfg_ready, m_ready);
    endtask

    task automatic run_stats(input int ncyc);
        logic clk_prev;
        for (int i = 0; i < NCH; i++) begin
            st_cnt[i] = 0; st_min[i] = 1000000; st_max[i] = 0; st_last[i] = -1;
        end
        st_clkmin = 1000000; st_clkmax = 0; st_clklast = -1; st_misalign = 0;
        clk_prev = clk_out[0];
        for (int t = 0; t < ncyc; t++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                if (ce_out[i]) begin
                    if (st_last[i] >= 0) begin
                        if (t - st_last[i] < st_min[i]) st_min[i] = t - st_last[i];
                        if (t - st_last[i] > st_max[i]) st_max[i] = t - st_last[i];
                    end
                    st_last[i] = t;
                    st_cnt[i]++;
                end
            end
            if (ce_out[1] && !ce_out[0]) st_misalign++;
            if (clk_out[0] && !clk_prev) begin
                if (st_clklast >= 0) begin
                    if (t - st_clklast < st_clkmin) st_clkmin = t - st_clklast;
                    if (t - st_clklast > st_clkmax) st_clkmax = t - st_clklast;
                end
                st_clklast = t;
            end
            clk_prev = clk_out[0];
        end
    endtask

    task automatic wait_lock(input int bound, output int edges, output int ce_seen);
        edges = 0;
        ce_seen = 0;
        while (!locked && edges < bound) begin
            step();
            edges++;
            if (ce_out != '0) ce_seen++;
        end
    endtask

    task automatic cfg_pulse(input logic [1:0] ch, input logic [W-1:0] inc);
        cfg_valid = 1'b1; cfg_channel = ch; cfg_increment = inc;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int edges, ce_seen;
        logic [W-1:0] rinc;

        chk("inc_for_27_of_135", inc_for(27, 135, W), 64'd3355443);

        // Reset and release with default increments.
        repeat (3) step();
        chk("rst_outputs", {ce_out, clk_out, locked, cfg_ready}, '0);
        rst = 1'b0;
        wait_lock(100, edges, ce_seen);
        chk("lock_edge_after_rst", edges, LD);
        chk("ce_before_lock", ce_seen, 0);
        run_stats(40);
        chk("dflt_ch0_gap_min", st_min[0], 2);
        chk("dflt_ch0_gap_max", st_max[0], 2);
        chk("dflt_clk0_period_min", st_clkmin, 4);
        chk("dflt_clk0_period_max", st_clkmax, 4);

        // Reprogram ch1 to quarter rate while locked.
        cfg_pulse(2'd1, W'(1 << 22));
        chk("lock_drop_on_cfg", locked, 1'b0);
        wait_lock(100, edges, ce_seen);
        chk("lock_edge_after_cfg", edges, LD);
        run_stats(60);
        chk("ch1_gap", {st_min[1], st_max[1]}, {32'd4, 32'd4});
        chk("ch0_gap", {st_min[0], st_max[0]}, {32'd2, 32'd2});
        chk("ch1_phase_aligned", st_misalign, 0);

        // Non power-of-two ratio: 135/27 gives exactly 5-cycle spacing.
        cfg_pulse(2'd0, W'(3355444));
        wait_lock(100, edges, ce_seen);
        run_stats(5010);
        chk("div5_gap_min", st_min[0], 5);
        chk("div5_gap_max", st_max[0], 5);
        chk("div5_count_ge_1000", st_cnt[0] >= 1000, 1'b1);

        cfg_pulse(2'd0, '0);
        wait_lock(100, edges, ce_seen);
        run_stats(200);
        chk("inc0_no_pulses", st_cnt[0], 0);

        // Out-of-range channel: no restart and rates unchanged.
        cfg_pulse(2'd3, W'(1 << 23));
        chk("bad_ch_locked_stays", locked, 1'b1);
        run_stats(40);
        chk("bad_ch_ch1_gap", st_min[1], 4);
        chk("bad_ch_ch0_silent", st_cnt[0], 0);

        // Three back-to-back cfgs; last write per channel wins.
        cfg_valid = 1'b1;
        cfg_channel = 2'd0; cfg_increment = W'(1 << 21); step();
        cfg_channel = 2'd1; cfg_increment = W'(1 << 23); step();
        cfg_channel = 2'd0; cfg_increment = W'(1 << 20); step();
        cfg_valid = 1'b0;
        wait_lock(100, edges, ce_seen);
        chk("lock_after_burst", edges, LD);
        run_stats(80);
        chk("burst_ch0_gap", st_min[0], 16);
        chk("burst_ch1_gap", st_min[1], 2);

        // Reset mid-lock with a cfg pending.
        rst = 1'b1; cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_increment = W'(5);
        step();
        chk("midrst_outputs", {ce_out, clk_out, locked, cfg_ready}, '0);
        rst = 1'b0; cfg_valid = 1'b0;
        wait_lock(100, edges, ce_seen);
        chk("midrst_lock_edge", edges, LD);
        run_stats(40);
        chk("midrst_ch0_default", {st_min[0], st_max[0]}, {32'd2, 32'd2});
        chk("midrst_ch1_default", st_min[1], 2);

        // Randomised traffic checked cycle by cycle against the model.
        for (int t = 0; t < 4000; t++) begin
            rst = ($urandom_range(499) == 0);
            cfg_valid = ($urandom_range(29) == 0);
            cfg_channel = 2'($urandom_range(3));
            case ($urandom_range(3))
                0: rinc = '0;
                1: rinc = W'(1) << $urandom_range(W-1, 16);
                2: rinc = W'($urandom);
                default: rinc = W'($urandom_range(400000, 1));
            endcase
            cfg_increment = rinc;
            step();
        end
        rst = 1'b0; cfg_valid = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
